// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter sharing one RAM (1-cycle registered read).
// Optional build macro RAM_ARB_LOCK_EN adds i_a_lock for atomic port-A read-modify-write.
module ram_arbiter #(
  parameter int g_RAM_WIDTH = 9,
  parameter int g_RAM_ADDR  = 11
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_a_req,
  input  logic                   i_a_we,
  input  logic [g_RAM_ADDR-1:0]  i_a_addr,
  input  logic [g_RAM_WIDTH-1:0] i_a_wdata,
`ifdef RAM_ARB_LOCK_EN
  input  logic                   i_a_lock,
`endif
  output logic                   o_a_gnt,
  output logic                   o_a_rvalid,
  output logic [g_RAM_WIDTH-1:0] o_a_rdata,
  input  logic                   i_b_req,
  input  logic                   i_b_we,
  input  logic [g_RAM_ADDR-1:0]  i_b_addr,
  input  logic [g_RAM_WIDTH-1:0] i_b_wdata,
  output logic                   o_b_gnt,
  output logic                   o_b_rvalid,
  output logic [g_RAM_WIDTH-1:0] o_b_rdata,
  output logic                   o_ram_en,
  output logic                   o_ram_we,
  output logic                   o_ram_re,
  output logic [g_RAM_ADDR-1:0]  o_ram_addr,
  output logic [g_RAM_WIDTH-1:0] o_ram_data,
  input  logic [g_RAM_WIDTH-1:0] i_ram_data
);

  localparam logic [0:0] PTR_A = 1'b0;
  localparam logic [0:0] PTR_B = 1'b1;

  logic [0:0]             r_ptr;
  logic                   w_a_gnt;
  logic                   w_b_gnt;
  logic                   w_a_acc;
  logic                   w_b_acc;
  logic                   w_acc;
  logic                   w_locked;
  logic                   w_sel_we;
  logic [g_RAM_ADDR-1:0]  w_sel_addr;
  logic [g_RAM_WIDTH-1:0] w_sel_wdata;

  logic                   r_ram_en;
  logic                   r_ram_we;
  logic                   r_ram_re;
  logic [g_RAM_ADDR-1:0]  r_ram_addr;
  logic [g_RAM_WIDTH-1:0] r_ram_data;

  logic                   r_tag1_vld;
  logic [0:0]             r_tag1_port;
  logic                   r_tag2_vld;
  logic [0:0]             r_tag2_port;

  logic                   r_a_rvalid;
  logic                   r_b_rvalid;
  logic [g_RAM_WIDTH-1:0] r_a_rdata;
  logic [g_RAM_WIDTH-1:0] r_b_rdata;

`ifdef RAM_ARB_LOCK_EN
  localparam logic [0:0] ST_OPEN   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0] r_lock_state;

  // Lock FSM: any port-A accept reloads the state from i_a_lock
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lock_state <= ST_OPEN;
    end else if (w_a_acc) begin
      r_lock_state <= i_a_lock ? ST_LOCKED : ST_OPEN;
    end else begin
      r_lock_state <= r_lock_state;
    end
  end

  assign w_locked = (r_lock_state == ST_LOCKED);
`else
  assign w_locked = 1'b0;
`endif

  // Grant selection: idle ports still show the pointer port as granted
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (i_rst) begin
      w_a_gnt = 1'b0;
      w_b_gnt = 1'b0;
    end else if (w_locked) begin
      w_a_gnt = 1'b1;
      w_b_gnt = 1'b0;
    end else begin
      case ({i_a_req, i_b_req})
        2'b10: begin
          w_a_gnt = 1'b1;
          w_b_gnt = 1'b0;
        end
        2'b01: begin
          w_a_gnt = 1'b0;
          w_b_gnt = 1'b1;
        end
        default: begin
          w_a_gnt = (r_ptr == PTR_A);
          w_b_gnt = (r_ptr == PTR_B);
        end
      endcase
    end
  end

  assign w_a_acc = i_a_req & w_a_gnt;
  assign w_b_acc = i_b_req & w_b_gnt;
  assign w_acc   = w_a_acc | w_b_acc;

  assign w_sel_we    = w_b_acc ? i_b_we    : i_a_we;
  assign w_sel_addr  = w_b_acc ? i_b_addr  : i_a_addr;
  assign w_sel_wdata = w_b_acc ? i_b_wdata : i_a_wdata;

  // Pointer always moves to the port that was not accepted
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= PTR_A;
    end else if (w_a_acc) begin
      r_ptr <= PTR_B;
    end else if (w_b_acc) begin
      r_ptr <= PTR_A;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Issue stage: strobes pulse for one cycle, address/data hold when idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_re   <= 1'b0;
      r_ram_addr <= {g_RAM_ADDR{1'b0}};
      r_ram_data <= {g_RAM_WIDTH{1'b0}};
    end else if (w_acc) begin
      r_ram_en   <= 1'b1;
      r_ram_we   <= w_sel_we;
      r_ram_re   <= ~w_sel_we;
      r_ram_addr <= w_sel_addr;
      r_ram_data <= w_sel_we ? w_sel_wdata : {g_RAM_WIDTH{1'b0}};
    end else begin
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_re   <= 1'b0;
      r_ram_addr <= r_ram_addr;
      r_ram_data <= r_ram_data;
    end
  end

  // Read tag pipeline: stage 1 tracks the RAM strobe, stage 2 the RAM output
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tag1_vld  <= 1'b0;
      r_tag1_port <= PTR_A;
      r_tag2_vld  <= 1'b0;
      r_tag2_port <= PTR_A;
    end else begin
      r_tag1_vld  <= w_acc & ~w_sel_we;
      r_tag1_port <= w_b_acc ? PTR_B : PTR_A;
      r_tag2_vld  <= r_tag1_vld;
      r_tag2_port <= r_tag1_port;
    end
  end

  // Read return: only the tagged port updates its data register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= {g_RAM_WIDTH{1'b0}};
      r_b_rdata  <= {g_RAM_WIDTH{1'b0}};
    end else begin
      r_a_rvalid <= r_tag2_vld & (r_tag2_port == PTR_A);
      r_b_rvalid <= r_tag2_vld & (r_tag2_port == PTR_B);
      if (r_tag2_vld && (r_tag2_port == PTR_A)) begin
        r_a_rdata <= i_ram_data;
      end else begin
        r_a_rdata <= r_a_rdata;
      end
      if (r_tag2_vld && (r_tag2_port == PTR_B)) begin
        r_b_rdata <= i_ram_data;
      end else begin
        r_b_rdata <= r_b_rdata;
      end
    end
  end

  assign o_a_gnt    = w_a_gnt;
  assign o_b_gnt    = w_b_gnt;
  assign o_a_rvalid = r_a_rvalid;
  assign o_b_rvalid = r_b_rvalid;
  assign o_a_rdata  = r_a_rdata;
  assign o_b_rdata  = r_b_rdata;
  assign o_ram_en   = r_ram_en;
  assign o_ram_we   = r_ram_we;
  assign o_ram_re   = r_ram_re;
  assign o_ram_addr = r_ram_addr;
  assign o_ram_data = r_ram_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed table-driven bench for ram_arbiter with a behavioural 1-cycle RAM.
// Define RAM_ARB_LOCK_EN for both files to exercise the lock sequence.
module tb_ram_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic        a_req, a_we, b_req, b_we;
  logic [10:0] a_addr, b_addr;
  logic [8:0]  a_wdata, b_wdata;
  logic        a_lock;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [8:0]  a_rdata, b_rdata;
  logic        ram_en, ram_we, ram_re;
  logic [10:0] ram_addr;
  logic [8:0]  ram_wdata;
  logic [8:0]  ram_q;
  logic [8:0]  mem [0:2047];

  int n_total;
  int n_bad;

  ram_arbiter #(.g_RAM_WIDTH(9), .g_RAM_ADDR(11)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
`ifdef RAM_ARB_LOCK_EN
    .i_a_lock(a_lock),
`endif
    .o_a_gnt(a_gnt), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_re(ram_re),
    .o_ram_addr(ram_addr), .o_ram_data(ram_wdata), .i_ram_data(ram_q)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Behavioural RAM: synchronous write, registered read
  always @(posedge i_clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_en && ram_re) ram_q <= mem[ram_addr];
  end

  typedef struct {
    logic        a_req; logic a_we; logic [10:0] a_addr; logic [8:0] a_wd;
    logic        b_req; logic b_we; logic [10:0] b_addr; logic [8:0] b_wd;
    logic        e_agnt; logic e_bgnt; logic e_en; logic e_we; logic e_re; logic [10:0] e_addr;
    logic        e_arv; logic [8:0] e_ard; logic e_brv; logic [8:0] e_brd;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_req = 1'b0; a_we = 1'b0; a_addr = 11'h000; a_wdata = 9'h000; a_lock = 1'b0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 11'h000; b_wdata = 9'h000;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    ram_q   = 9'h000;
    for (int i = 0; i < 2048; i++) mem[i] = 9'h000;

    //          a_req a_we a_addr   a_wd    b_req b_we b_addr   b_wd    agnt bgnt en   we   re   addr     arv  ard     brv  brd
    vt[0]  = '{1'b1, 1'b1, 11'h010, 9'h1A5, 1'b0, 1'b0, 11'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 9'h000, 1'b0, 9'h000};
    vt[1]  = '{1'b1, 1'b0, 11'h010, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 11'h010, 1'b0, 9'h000, 1'b0, 9'h000};
    vt[2]  = '{1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 11'h010, 1'b0, 9'h000, 1'b0, 9'h000};
    vt[3]  = '{1'b0, 1'b0, 11'h000, 9'h000, 1'b1, 1'b1, 11'h002, 9'h0CC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h010, 1'b0, 9'h000, 1'b0, 9'h000};
    vt[4]  = '{1'b1, 1'b0, 11'h002, 9'h000, 1'b1, 1'b0, 11'h002, 9'h000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 11'h002, 1'b1, 9'h1A5, 1'b0, 9'h000};
    vt[5]  = '{1'b1, 1'b0, 11'h010, 9'h000, 1'b1, 1'b0, 11'h002, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 11'h002, 1'b0, 9'h1A5, 1'b0, 9'h000};
    vt[6]  = '{1'b1, 1'b0, 11'h010, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 11'h002, 1'b0, 9'h1A5, 1'b0, 9'h000};
    vt[7]  = '{1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 11'h010, 1'b1, 9'h0CC, 1'b0, 9'h000};
    vt[8]  = '{1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h010, 1'b0, 9'h0CC, 1'b1, 9'h0CC};
    vt[9]  = '{1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h010, 1'b1, 9'h1A5, 1'b0, 9'h0CC};
    vt[10] = '{1'b1, 1'b1, 11'h001, 9'h055, 1'b0, 1'b0, 11'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h010, 1'b0, 9'h1A5, 1'b0, 9'h0CC};
    vt[11] = '{1'b0, 1'b0, 11'h000, 9'h000, 1'b1, 1'b1, 11'h003, 9'h111, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 11'h001, 1'b0, 9'h1A5, 1'b0, 9'h0CC};
    vt[12] = '{1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 11'h003, 1'b0, 9'h1A5, 1'b0, 9'h0CC};
    vt[13] = '{1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h003, 1'b0, 9'h1A5, 1'b0, 9'h0CC};

    // Reset held for two edges with both requests high
    idle_inputs();
    i_rst = 1'b1;
    a_req = 1'b1;
    b_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk);
      #1;
      chk($sformatf("rst%0d a_gnt", k), a_gnt, 1'b0);
      chk($sformatf("rst%0d b_gnt", k), b_gnt, 1'b0);
      chk($sformatf("rst%0d ram_en", k), ram_en, 1'b0);
      chk($sformatf("rst%0d a_rvalid", k), a_rvalid, 1'b0);
      chk($sformatf("rst%0d b_rvalid", k), b_rvalid, 1'b0);
      chk($sformatf("rst%0d a_rdata", k), a_rdata, 9'h000);
    end
    i_rst = 1'b0;
    #1;
    chk("post-rst a_gnt", a_gnt, 1'b1);
    chk("post-rst b_gnt", b_gnt, 1'b0);
    idle_inputs();

    // Vector table: write/read, read-after-write, mixed contention, hold behaviour
    for (int k = 0; k < 14; k++) begin
      @(negedge i_clk);
      a_req = vt[k].a_req; a_we = vt[k].a_we; a_addr = vt[k].a_addr; a_wdata = vt[k].a_wd;
      b_req = vt[k].b_req; b_we = vt[k].b_we; b_addr = vt[k].b_addr; b_wdata = vt[k].b_wd;
      #1;
      chk($sformatf("v%0d a_gnt", k), a_gnt, vt[k].e_agnt);
      chk($sformatf("v%0d b_gnt", k), b_gnt, vt[k].e_bgnt);
      chk($sformatf("v%0d ram_en", k), ram_en, vt[k].e_en);
      chk($sformatf("v%0d ram_we", k), ram_we, vt[k].e_we);
      chk($sformatf("v%0d ram_re", k), ram_re, vt[k].e_re);
      chk($sformatf("v%0d ram_addr", k), ram_addr, vt[k].e_addr);
      chk($sformatf("v%0d a_rvalid", k), a_rvalid, vt[k].e_arv);
      chk($sformatf("v%0d a_rdata", k), a_rdata, vt[k].e_ard);
      chk($sformatf("v%0d b_rvalid", k), b_rvalid, vt[k].e_brv);
      chk($sformatf("v%0d b_rdata", k), b_rdata, vt[k].e_brd);
    end

    // Contention: both ports read continuously for six accepts, A first
    for (int i = 0; i < 9; i++) begin
      @(negedge i_clk);
      idle_inputs();
      a_req = (i < 6); a_addr = 11'h001;
      b_req = (i < 6); b_addr = 11'h002;
      #1;
      if (i < 6) begin
        chk($sformatf("cont%0d a_gnt", i), a_gnt, (i % 2) == 0);
        chk($sformatf("cont%0d b_gnt", i), b_gnt, (i % 2) == 1);
      end
      if (i >= 1 && i <= 6) begin
        chk($sformatf("cont%0d ram_re", i), ram_re, 1'b1);
        chk($sformatf("cont%0d ram_addr", i), ram_addr, ((i - 1) % 2 == 0) ? 11'h001 : 11'h002);
      end
      if (i >= 3) begin
        chk($sformatf("cont%0d a_rvalid", i), a_rvalid, ((i - 3) % 2) == 0);
        chk($sformatf("cont%0d b_rvalid", i), b_rvalid, ((i - 3) % 2) == 1);
        if (((i - 3) % 2) == 0) chk($sformatf("cont%0d a_rdata", i), a_rdata, 9'h055);
        else                    chk($sformatf("cont%0d b_rdata", i), b_rdata, 9'h0CC);
      end else begin
        chk($sformatf("cont%0d a_rvalid", i), a_rvalid, 1'b0);
        chk($sformatf("cont%0d b_rvalid", i), b_rvalid, 1'b0);
      end
    end

    // Starvation: B holds a write request while A toggles every cycle
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      idle_inputs();
      a_req = (i < 6) && ((i % 2) == 0); a_we = 1'b1; a_addr = 11'h005; a_wdata = 9'(i);
      b_req = (i < 6);                   b_we = 1'b1; b_addr = 11'h004; b_wdata = 9'h077;
      #1;
      if (i < 6) begin
        chk($sformatf("starv%0d a_gnt", i), a_gnt, (i % 2) == 0);
        chk($sformatf("starv%0d b_gnt", i), b_gnt, (i % 2) == 1);
      end
      chk($sformatf("starv%0d a_rvalid", i), a_rvalid, 1'b0);
      chk($sformatf("starv%0d b_rvalid", i), b_rvalid, 1'b0);
    end

    // Reset mid-read: the in-flight read must never return
    @(negedge i_clk);
    idle_inputs();
    a_req = 1'b1; a_addr = 11'h001;
    #1;
    chk("mrst c0 a_gnt", a_gnt, 1'b1);
    @(negedge i_clk);
    idle_inputs();
    i_rst = 1'b1;
    #1;
    chk("mrst c1 a_gnt", a_gnt, 1'b0);
    chk("mrst c1 b_gnt", b_gnt, 1'b0);
    chk("mrst c1 ram_re", ram_re, 1'b1);
    @(negedge i_clk);
    i_rst = 1'b0;
    a_req = 1'b1; a_addr = 11'h003;
    #1;
    chk("mrst c2 ram_en", ram_en, 1'b0);
    chk("mrst c2 a_rdata", a_rdata, 9'h000);
    chk("mrst c2 a_gnt", a_gnt, 1'b1);
    chk("mrst c2 a_rvalid", a_rvalid, 1'b0);
    for (int i = 3; i < 7; i++) begin
      @(negedge i_clk);
      idle_inputs();
      #1;
      if (i == 3) begin
        chk("mrst c3 ram_re", ram_re, 1'b1);
        chk("mrst c3 ram_addr", ram_addr, 11'h003);
      end
      chk($sformatf("mrst c%0d a_rvalid", i), a_rvalid, i == 5);
      chk($sformatf("mrst c%0d b_rvalid", i), b_rvalid, 1'b0);
      if (i == 5) chk("mrst c5 a_rdata", a_rdata, 9'h111);
    end

`ifdef RAM_ARB_LOCK_EN
    // Lock: B is shut out until A's unlocking write is accepted
    @(negedge i_clk);
    idle_inputs();
    a_req = 1'b1; a_addr = 11'h001; a_lock = 1'b1;
    #1;
    chk("lock c0 a_gnt", a_gnt, 1'b1);
    for (int i = 1; i < 3; i++) begin
      @(negedge i_clk);
      idle_inputs();
      b_req = 1'b1; b_addr = 11'h002;
      #1;
      chk($sformatf("lock c%0d a_gnt", i), a_gnt, 1'b1);
      chk($sformatf("lock c%0d b_gnt", i), b_gnt, 1'b0);
    end
    @(negedge i_clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 11'h001; a_wdata = 9'h0AA; a_lock = 1'b0;
    #1;
    chk("lock c3 a_gnt", a_gnt, 1'b1);
    chk("lock c3 b_gnt", b_gnt, 1'b0);
    @(negedge i_clk);
    a_req = 1'b0; a_we = 1'b0;
    #1;
    chk("lock c4 b_gnt", b_gnt, 1'b1);
    chk("lock c4 a_gnt", a_gnt, 1'b0);
    @(negedge i_clk);
    idle_inputs();
    repeat (4) @(negedge i_clk);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
